pixel_source: RTL and testbench

Upstream colour source for `signal_generator`. It holds a low-resolution cell framebuffer of 32×48 cells at 12-bit RGB and is written by 32-bit GPU instructions. It follows the scan using the generator's `o_pixel_x_clock`, `o_pixel_y_clock` and `o_screen_reset` strobes, and presents the current cell colour on `o_color`, which drives the generator's `i_color`. A fill state machine clears the whole buffer on command.

---
 rtl/vga_gpu_pkg.sv | 39 +++
 rtl/pixel_source_if.sv | 26 ++
 rtl/pixel_source_cell_ram.sv | 42 ++++
 rtl/pixel_source.sv | 159 +++++++++++++++
 tb/tb_pixel_source.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_gpu_pkg.sv
// Shared definitions for the VGA GPU blocks: geometry defaults, colour width,
// instruction opcodes and field layout, and the fill FSM state encoding.
package vga_gpu_pkg;

    localparam int unsigned COLOR_W           = 12;
    localparam int unsigned INSTR_W           = 32;
    localparam int unsigned DEF_COLS          = 32;
    localparam int unsigned DEF_ROWS          = 48;
    localparam int unsigned DEF_LINES_PER_ROW = 10;

    localparam logic [3:0] OP_NOP        = 4'h0;
    localparam logic [3:0] OP_WRITE_CELL = 4'h1;
    localparam logic [3:0] OP_FILL       = 4'h2;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 28;
    localparam int unsigned COL_MSB    = 27;
    localparam int unsigned COL_LSB    = 23;
    localparam int unsigned ROW_MSB    = 21;
    localparam int unsigned ROW_LSB    = 16;
    localparam int unsigned COLOR_MSB  = 11;
    localparam int unsigned COLOR_LSB  = 0;

    // Instruction word laid out to match the bit positions above
    typedef struct packed {
        logic [3:0]         opcode;
        logic [4:0]         col;
        logic               rsvd_hi;
        logic [5:0]         row;
        logic [3:0]         rsvd_lo;
        logic [COLOR_W-1:0] color;
    } instr_t;

    typedef enum logic {
        FSM_IDLE,
        FSM_FILL
    } fill_state_e;

endpackage

// File: rtl/pixel_source_if.sv
// Scan strobes, instruction bus and colour/status outputs of pixel_source.
interface pixel_source_if;
    import vga_gpu_pkg::*;

    logic               i_pixel_x_clock;
    logic               i_pixel_y_clock;
    logic               i_screen_reset;
    logic [INSTR_W-1:0] i_instruction;
    logic               i_instruction_ready;
    logic [COLOR_W-1:0] o_color;
    logic               o_busy;
    logic               o_overrun;

    modport master (
        output i_pixel_x_clock, i_pixel_y_clock, i_screen_reset,
        output i_instruction, i_instruction_ready,
        input  o_color, o_busy, o_overrun
    );

    modport slave (
        input  i_pixel_x_clock, i_pixel_y_clock, i_screen_reset,
        input  i_instruction, i_instruction_ready,
        output o_color, o_busy, o_overrun
    );

endinterface

// File: rtl/pixel_source_cell_ram.sv
// Simple dual-port cell RAM: one write port, one registered read port that
// returns the pre-write contents when both ports hit the same address.
module cell_ram #(
    parameter int unsigned DEPTH  = 1536,
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    // Storage array has no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pixel_source.sv
// Cell framebuffer colour source: tracks the scan position from the generator
// strobes, decodes GPU instructions and runs the full-buffer fill FSM.
module pixel_source
    import vga_gpu_pkg::*;
#(
    parameter int unsigned COLS          = DEF_COLS,
    parameter int unsigned ROWS          = DEF_ROWS,
    parameter int unsigned LINES_PER_ROW = DEF_LINES_PER_ROW
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    pixel_source_if.slave  bus
);

    localparam int unsigned DEPTH  = COLS * ROWS;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned LINE_W = $clog2(LINES_PER_ROW);

    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [LINE_W-1:0]  line_q, line_d;

    fill_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  fill_addr_q, fill_addr_d;
    logic [COLOR_W-1:0] fill_color_q, fill_color_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic               wr_en_c;
    logic [ADDR_W-1:0]  wr_addr_c;
    logic [COLOR_W-1:0] wr_data_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic [COLOR_W-1:0] rd_color;

    instr_t             instr;
    logic               row_ok_c;
    logic               unused_instr;

    assign instr        = instr_t'(bus.i_instruction);
    assign unused_instr = ^{instr.rsvd_hi, instr.rsvd_lo};
    assign row_ok_c     = 32'(instr.row) < ROWS;

    // Scan position; screen reset beats y, y beats x
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        line_d = line_q;
        if (bus.i_screen_reset) begin
            col_d  = '0;
            row_d  = '0;
            line_d = '0;
        end else if (bus.i_pixel_y_clock) begin
            col_d = '0;
            if (line_q == LINE_W'(LINES_PER_ROW - 1)) begin
                line_d = '0;
                if (row_q != ROW_W'(ROWS - 1)) begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                line_d = line_q + LINE_W'(1);
            end
        end else if (bus.i_pixel_x_clock && (col_q != COL_W'(COLS - 1))) begin
            col_d = col_q + COL_W'(1);
        end
    end

    assign rd_addr_c = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

    // Instruction decode and fill sequencing
    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        fill_color_d = fill_color_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        wr_en_c      = 1'b0;
        wr_addr_c    = fill_addr_q;
        wr_data_c    = fill_color_q;
        case (state_q)
            FSM_IDLE: begin
                if (bus.i_instruction_ready) begin
                    if (instr.opcode == OP_WRITE_CELL) begin
                        if (row_ok_c) begin
                            wr_en_c   = 1'b1;
                            wr_addr_c = ADDR_W'(instr.row) * ADDR_W'(COLS)
                                      + ADDR_W'(instr.col);
                            wr_data_c = instr.color;
                        end
                    end else if (instr.opcode == OP_FILL) begin
                        state_d      = FSM_FILL;
                        fill_addr_d  = '0;
                        fill_color_d = instr.color;
                        busy_d       = 1'b1;
                    end
                end
            end
            FSM_FILL: begin
                wr_en_c = 1'b1;
                // Anything arriving while busy, last write cycle included, is lost
                if (bus.i_instruction_ready) begin
                    overrun_d = 1'b1;
                end
                if (fill_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = FSM_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    fill_addr_d = fill_addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = FSM_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            line_q       <= '0;
            state_q      <= FSM_IDLE;
            fill_addr_q  <= '0;
            fill_color_q <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            line_q       <= line_d;
            state_q      <= state_d;
            fill_addr_q  <= fill_addr_d;
            fill_color_q <= fill_color_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    cell_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (COLOR_W),
        .ADDR_W (ADDR_W)
    ) u_cell_ram (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .wr_en   (wr_en_c),
        .wr_addr (wr_addr_c),
        .wr_data (wr_data_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_color)
    );

    assign bus.o_color   = rd_color;
    assign bus.o_busy    = busy_q;
    assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_pixel_source.sv
// Scoreboard bench for pixel_source: stimulus queues expected outputs tagged
// with the cycle they must appear in; a negedge monitor pops and compares.
module tb_pixel_source;
    import vga_gpu_pkg::*;

    localparam int unsigned K_COLOR = 0;
    localparam int unsigned K_BUSY  = 1;
    localparam int unsigned K_OVR   = 2;

    typedef struct {
        int unsigned cyc;
        int unsigned kind;
        logic [11:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];

    pixel_source_if bus();

    pixel_source #(
        .COLS          (32),
        .ROWS          (48),
        .LINES_PER_ROW (10)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] actual(input int unsigned kind);
        case (kind)
            K_COLOR: return bus.o_color;
            K_BUSY:  return {11'b0, bus.o_busy};
            default: return {11'b0, bus.o_overrun};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        int i;
        logic [11:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                act = actual(sb[i].kind);
                tests++;
                if (act !== sb[i].val) begin
                    fails++;
                    $display("FAIL %s: got 0x%03h, expected 0x%03h (cycle %0d)",
                             sb[i].name, act, sb[i].val, cyc);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s: check window missed (cycle %0d)", sb[i].name, cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned kind, input logic [11:0] val,
                             input int unsigned off, input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_color_next(input logic [11:0] val, input string name);
        expect_at(K_COLOR, val, 1, name);
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) tick();
    endtask

    task automatic strobe(input bit x, input bit y, input bit sr);
        bus.i_pixel_x_clock = x;
        bus.i_pixel_y_clock = y;
        bus.i_screen_reset  = sr;
        tick();
        bus.i_pixel_x_clock = 1'b0;
        bus.i_pixel_y_clock = 1'b0;
        bus.i_screen_reset  = 1'b0;
    endtask

    task automatic goto_cell(input int unsigned col, input int unsigned row);
        strobe(0, 0, 1);
        repeat (row * 10) strobe(0, 1, 0);
        repeat (col) strobe(1, 0, 0);
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.i_instruction       = ins;
        bus.i_instruction_ready = 1'b1;
        tick();
        bus.i_instruction_ready = 1'b0;
        bus.i_instruction       = '0;
    endtask

    function automatic logic [31:0] mk_write(input logic [4:0] col, input logic [5:0] row,
                                             input logic [11:0] color);
        return {OP_WRITE_CELL, col, 1'b0, row, 4'h0, color};
    endfunction

    function automatic logic [31:0] mk_fill(input logic [11:0] color);
        return {OP_FILL, 16'h0000, color};
    endfunction

    initial begin : stim
        int unsigned c;
        rst_n                   = 1'b0;
        bus.i_pixel_x_clock     = 1'b0;
        bus.i_pixel_y_clock     = 1'b0;
        bus.i_screen_reset      = 1'b0;
        bus.i_instruction       = '0;
        bus.i_instruction_ready = 1'b0;
        repeat (3) tick();
        expect_at(K_COLOR, 12'h000, 0, "reset color");
        expect_at(K_BUSY,  12'h000, 0, "reset busy");
        expect_at(K_OVR,   12'h000, 0, "reset overrun");
        tick();
        rst_n = 1'b1;
        tick();

        // Fill 0x00F: busy window of exactly 1536 cycles
        c = cyc;
        expect_at(K_BUSY, 12'h000, 0,    "busy before fill");
        expect_at(K_BUSY, 12'h001, 1,    "busy rises");
        expect_at(K_BUSY, 12'h001, 1536, "busy last fill cycle");
        expect_at(K_BUSY, 12'h000, 1537, "busy falls");
        expect_at(K_COLOR, 12'h00F, 1538, "fill color at 0,0");
        issue(mk_fill(12'h00F));
        wait_until(c + 1540);

        c = cyc;
        issue(mk_fill(12'h000));
        wait_until(c + 1540);

        // Single cell write and column stepping
        issue(mk_write(5'd3, 6'd0, 12'hF00));
        strobe(0, 0, 1);
        strobe(1, 0, 0);
        strobe(1, 0, 0);
        strobe(1, 0, 0);
        check_color_next(12'hF00, "col3 after 3 x");
        strobe(1, 0, 0);
        check_color_next(12'h000, "col4 after 4 x");

        // Line/row stepping
        strobe(0, 0, 1);
        repeat (9) strobe(0, 1, 0);
        check_color_next(12'h000, "row0 after 9 y");
        strobe(0, 1, 0);
        check_color_next(12'h000, "row1 before write");
        expect_at(K_COLOR, 12'h000, 1, "collision returns old");
        expect_at(K_COLOR, 12'h0F0, 2, "write visible next cycle");
        issue(mk_write(5'd0, 6'd1, 12'h0F0));
        strobe(0, 0, 1);
        repeat (9) strobe(0, 1, 0);
        check_color_next(12'h000, "row held through 9 y");
        strobe(0, 1, 0);
        check_color_next(12'h0F0, "row advances on 10th y");

        issue(mk_write(5'd31, 6'd1, 12'hABC));
        issue(mk_write(5'd1, 6'd0, 12'h555));
        repeat (31) strobe(1, 0, 0);
        check_color_next(12'hABC, "col31");
        repeat (29) strobe(1, 0, 0);
        check_color_next(12'hABC, "col saturates at 31");
        strobe(1, 1, 0);
        check_color_next(12'h0F0, "y beats x");
        strobe(1, 0, 1);
        check_color_next(12'h000, "screen reset beats x");
        strobe(1, 0, 0);
        check_color_next(12'h555, "col1 row0");

        issue(mk_write(5'd0, 6'd47, 12'h777));
        goto_cell(0, 49);
        check_color_next(12'h777, "row saturates at 47");

        // Instructions dropped while filling
        expect_at(K_OVR, 12'h000, 0, "overrun clear before fill");
        c = cyc;
        expect_at(K_BUSY, 12'h001, 1536, "busy last cycle 5A5");
        expect_at(K_BUSY, 12'h000, 1537, "busy falls 5A5");
        issue(mk_fill(12'h5A5));
        wait_until(c + 10);
        expect_at(K_OVR, 12'h001, 1, "overrun on drop");
        issue(mk_write(5'd0, 6'd0, 12'hFFF));
        wait_until(c + 1536);
        issue(mk_write(5'd31, 6'd47, 12'hFFF));
        wait_until(c + 1540);
        goto_cell(31, 47);
        check_color_next(12'h5A5, "last-cycle write dropped");
        goto_cell(0, 0);
        check_color_next(12'h5A5, "mid-fill write dropped");
        expect_at(K_OVR, 12'h001, 0, "overrun sticky");

        // Reset in the middle of a fill
        c = cyc;
        issue(mk_fill(12'h321));
        wait_until(c + 600);
        expect_at(K_OVR,  12'h001, 0, "overrun sticky in fill");
        expect_at(K_BUSY, 12'h001, 0, "busy mid fill");
        wait_until(c + 701);
        rst_n = 1'b0;
        expect_at(K_BUSY,  12'h000, 0, "busy drops on reset");
        expect_at(K_OVR,   12'h000, 0, "overrun cleared by reset");
        expect_at(K_COLOR, 12'h000, 0, "color cleared by reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        expect_at(K_BUSY, 12'h000, 0, "idle after reset");
        goto_cell(0, 0);
        check_color_next(12'h321, "partial fill cell 0");
        goto_cell(27, 21);
        check_color_next(12'h321, "partial fill cell 699");
        strobe(1, 0, 0);
        check_color_next(12'h5A5, "cell 700 untouched");

        // Out-of-range row and unknown opcodes
        issue(mk_write(5'd0, 6'd50, 12'hBAD));
        issue(32'h7000_0BAD);
        issue(32'h0000_0BAD);
        expect_at(K_OVR,  12'h000, 0, "row 50 not flagged");
        expect_at(K_BUSY, 12'h000, 0, "opcode 7 no fill");
        goto_cell(0, 0);
        check_color_next(12'h321, "opcode 7 no write");

        repeat (4) tick();
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending: %0d expectations never checked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
